uart_html_reader: RTL and testbench
===================================

UART_HTML_READER -- requirements
Module: uart_html_reader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set character buffer entries (power of two, at least 2).
REQ-003 Parameter EOT_CHAR, default 8'h04, SHALL set the end-of-document byte value.
REQ-004 Port clock, input, 1, SHALL be the single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the synchronous, active-high reset.
REQ-006 Port rx, input, 1, SHALL be the asynchronous UART serial line (idle high, 8N1, LSB first).
REQ-007 Port next_char, input, 1, SHALL be the consumer's one-cycle request to advance to the next character.
REQ-008 Port char, output, `CHAR_BITES (8), SHALL present the current head-of-buffer character.
REQ-009 Port char_valid, output, 1, SHALL be high when char holds an unconsumed character.
REQ-010 Port eof, output, 1, SHALL be high when the document has ended and all characters are consumed.
REQ-011 Port frame_error, output, 1, SHALL pulse for one cycle on a bad stop bit.
REQ-012 Port overrun, output, 1, SHALL be a sticky flag set when a byte is dropped because the buffer is full.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before use; all latency figures count from the synchronized signal.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized rx low; the bit counter is cleared.
REQ-016 START SHALL wait CLKS_PER_BIT/2 cycles (integer divide), then resample: low -> DATA; high (glitch) -> IDLE, no flags raised.
REQ-017 DATA SHALL sample rx every CLKS_PER_BIT cycles, shifting 8 bits LSB first, then -> STOP.
REQ-018 STOP SHALL sample once after CLKS_PER_BIT cycles: high -> byte accepted; low -> frame_error pulse and byte discarded; either way -> IDLE.
REQ-019 An accepted byte equal to EOT_CHAR SHALL NOT be buffered; it sets the internal eot_seen flag.
REQ-020 Accepted bytes arriving after eot_seen SHALL be discarded silently until reset.
REQ-021 Any other accepted byte SHALL be written to the FIFO in the cycle after the STOP sample.
REQ-022 A write to a full FIFO with no same-cycle pop SHALL drop the byte and set overrun.
REQ-023 A write and a pop in the same cycle on a full FIFO SHALL both succeed; overrun is not set.
REQ-024 char SHALL equal the FIFO head, and char_valid SHALL equal FIFO not empty.
REQ-025 next_char while char_valid is high SHALL pop the head; char and char_valid reflect the new head one cycle later.
REQ-026 next_char while char_valid is low SHALL be ignored: no pointer change and no error.
REQ-027 A simultaneous write and pop on an empty FIFO SHALL perform the write only.
REQ-028 A byte written to an empty FIFO SHALL appear on char with char_valid high on the cycle after the write.
REQ-029 eof SHALL be registered, equal to eot_seen AND FIFO empty, and remain high until reset.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; an occupancy counter of log2(FIFO_DEPTH)+1 bits SHALL distinguish full from empty.

Reset
REQ-031 On reset: FSM IDLE; FIFO empty; eot_seen 0; char 8'h00; char_valid 0; eof 0; frame_error 0; overrun 0.
REQ-032 Reset asserted mid-frame SHALL abandon the partial byte; the FSM re-arms only on a new falling edge after reset deasserts.
REQ-033 Reset SHALL dominate next_char and FIFO writes in the same cycle.

Verification
REQ-034 Use CLKS_PER_BIT=4, FIFO_DEPTH=4. Send 8'h3C ('<') -> char=8'h3C, char_valid=1; pulse next_char -> char_valid=0 next cycle, eof=0.
REQ-035 Send 'h','i', then 8'h04, with no pops -> char='h', eof=0; pop twice -> char_valid=0 and eof=1; a later byte 'x' is ignored.
REQ-036 Send 6 bytes 8'h41-8'h46 with no pops -> overrun=1 after the 5th byte; pops yield exactly 41,42,43,44.
REQ-037 Drive a 1-cycle low glitch, then a frame with stop bit low -> no FIFO write either time; frame_error pulses once (second case only).
REQ-038 Assert reset during bit 3 of 8'h55, then send 8'h2F -> only 8'h2F is buffered; all flags 0.
REQ-039 Fill the FIFO with 4 bytes, then pulse next_char in the write cycle of a 5th byte -> overrun=0; pops yield bytes 2-5 in order.

Source files
------------

// File: rtl/uart_html_reader.sv
// UART (8N1) byte receiver feeding a small character FIFO for a document reader.
// An EOT byte ends the document; eof rises once every buffered character is consumed.
module uart_html_reader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [7:0]  EOT_CHAR     = 8'h04
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       next_char,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       eof,
  output logic       frame_error,
  output logic       overrun
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int AW1    = AW + 1;
  localparam int CW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
  localparam logic [AW1-1:0] FULL_CNT  = AW1'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Stage p0/p1: synchronizer; p2 only delays p1 so a start needs a real falling edge
  logic rx_p0, rx_p1, rx_p2;
  logic start_edge;

  always_ff @(posedge clock) begin
    rx_p0 <= rx;
    rx_p1 <= rx_p0;
    rx_p2 <= rx_p1;
  end

  assign start_edge = rx_p2 & ~rx_p1;

  // Receiver: bit timing and framing, result lands in shift_p1 / vld_p1
  state_t              state;
  logic [CW-1:0]       clk_cnt;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   shift_p1;
  logic                vld_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      vld_p1      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      vld_p1      <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_p1 ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (rx_p1) vld_p1      <= 1'b1;
            else       frame_error <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == DATA && clk_cnt == BIT_LAST)
      shift_p1 <= {rx_p1, shift_p1[DATA_W-1:1]};
  end

  // Buffer stage: the accepted byte is written one cycle after the stop sample
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW1-1:0]    count;
  logic              eot_seen;
  logic              accept, push_req, pop, push;

  assign accept   = vld_p1 & ~eot_seen;
  assign push_req = accept & (shift_p1 != EOT_CHAR);
  assign pop      = next_char & (count != '0);
  // A full buffer still takes the byte when the head leaves in the same cycle
  assign push     = push_req & ((count != FULL_CNT) | pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      eot_seen <= 1'b0;
      eof      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept && shift_p1 == EOT_CHAR) eot_seen <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) overrun <= 1'b1;
      eof <= eof | (eot_seen & (count == '0));
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= shift_p1;
  end

  assign char_valid = (count != '0);
  assign char       = char_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_html_reader.sv
// Bench for uart_html_reader: directed table, hand-written corner sequences,
// and random traffic checked against a queue model of the character buffer.
module tb_uart_html_reader;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       next_char;
  logic [7:0] char;
  logic       char_valid;
  logic       eof;
  logic       frame_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  uart_html_reader #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .EOT_CHAR(8'h04)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .next_char(next_char),
    .char(char),
    .char_valid(char_valid),
    .eof(eof),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_error) fe_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    tick(CPB);
  endtask

  task automatic pop_pulse();
    next_char = 1'b1;
    tick(1);
    next_char = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rx        = 1'b1;
    next_char = 1'b0;
    tick(3);
    chk("rst_char", char, 8'h00);
    chk("rst_valid", char_valid, 0);
    chk("rst_eof", eof, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick(4);
  endtask

  initial begin
    int          fe0;
    logic [7:0]  d;
    logic [7:0]  q[$];
    logic        ovr_m;
    int          npop;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1};

    do_reset();

    // Single frames from an empty buffer
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      tick(CPB);
      chk("vec_valid", char_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk("vec_char", char, vecs[i].data);
      chk("vec_fe", fe_cnt - fe0, vecs[i].exp_fe);
      chk("vec_overrun", overrun, 0);
      if (vecs[i].exp_valid) begin
        pop_pulse();
        chk("vec_pop_valid", char_valid, 0);
        chk("vec_pop_eof", eof, 0);
      end
      tick(4);
    end

    // One-cycle low glitch: rejected in START, no flags
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    chk("glitch_valid", char_valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);

    // Document end
    do_reset();
    send_byte(8'h68);
    send_byte(8'h69);
    send_byte(8'h04);
    chk("eot_char", char, 8'h68);
    chk("eot_eof_early", eof, 0);
    pop_pulse();
    chk("eot_char2", char, 8'h69);
    pop_pulse();
    tick(2);
    chk("eot_valid", char_valid, 0);
    chk("eot_eof", eof, 1);
    send_byte(8'h78);
    chk("eot_after_valid", char_valid, 0);
    chk("eot_after_eof", eof, 1);

    // Overrun on the fifth byte
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
    chk("ovr_before", overrun, 0);
    send_byte(8'h45);
    chk("ovr_after5", overrun, 1);
    send_byte(8'h46);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_valid", char_valid, 1);
      chk("ovr_char", char, 8'h41 + 8'(i));
      pop_pulse();
    end
    chk("ovr_empty", char_valid, 0);

    // Reset in the middle of 8'h55, then a clean 8'h2F
    do_reset();
    d = 8'h55;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = d[3];
    tick(2);
    reset = 1'b1;
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    fe0 = fe_cnt;
    send_byte(8'h2F);
    chk("midrst_valid", char_valid, 1);
    chk("midrst_char", char, 8'h2F);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_eof", eof, 0);
    chk("midrst_fe", fe_cnt - fe0, 0);
    pop_pulse();
    chk("midrst_empty", char_valid, 0);

    // Pop in the same cycle as a write into a full buffer
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hB1 + 8'(i));
    send_frame(8'hB5, 1'b1);
    tick(1);
    pop_pulse();
    tick(4);
    chk("fullpop_overrun", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_valid", char_valid, 1);
      chk("fullpop_char", char, 8'hB2 + 8'(i));
      pop_pulse();
    end
    chk("fullpop_empty", char_valid, 0);

    // Random traffic against a queue model
    do_reset();
    q.delete();
    ovr_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'h04) d = 8'h05;
      send_byte(d);
      if (q.size() < DEPTH) q.push_back(d);
      else ovr_m = 1'b1;
      chk("rnd_valid", char_valid, (q.size() != 0));
      chk("rnd_overrun", overrun, ovr_m);
      if (q.size() != 0) chk("rnd_char", char, q[0]);
      npop = ($urandom_range(0, 3) == 0) ? 2 : int'($urandom_range(0, 1));
      for (int k = 0; k < npop; k++) begin
        pop_pulse();
        if (q.size() != 0) void'(q.pop_front());
        chk("rnd_pop_valid", char_valid, (q.size() != 0));
        if (q.size() != 0) chk("rnd_pop_char", char, q[0]);
      end
    end
    chk("rnd_eof", eof, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
